// File: rtl/wb_master_bridge_if.sv
// Command/response handshake plus Wishbone classic bus bundle for wb_master_bridge.
// The "master" modport is the bridge side; "slave" is the environment (command source + Wishbone slave).
interface wb_master_bridge_if #(
    parameter int AW = 32,
    parameter int DW = 32
) ();
    // Command port
    logic            cmd_valid_i;
    logic            cmd_ready_o;
    logic            cmd_we_i;
    logic [DW/8-1:0] cmd_sel_i;
    logic [AW-1:0]   cmd_adr_i;
    logic [DW-1:0]   cmd_dat_i;

    // Response port
    logic            rsp_valid_o;
    logic            rsp_ready_i;
    logic [DW-1:0]   rsp_dat_o;
    logic            rsp_err_o;

    // Wishbone classic initiator bus
    logic            wbm_cyc_o;
    logic            wbm_stb_o;
    logic            wbm_we_o;
    logic [DW/8-1:0] wbm_sel_o;
    logic [AW-1:0]   wbm_adr_o;
    logic [DW-1:0]   wbm_dat_o;
    logic [DW-1:0]   wbm_dat_i;
    logic            wbm_ack_i;

    modport master (
        input  cmd_valid_i, cmd_we_i, cmd_sel_i, cmd_adr_i, cmd_dat_i,
        output cmd_ready_o,
        output rsp_valid_o, rsp_dat_o, rsp_err_o,
        input  rsp_ready_i,
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        input  wbm_dat_i, wbm_ack_i
    );

    modport slave (
        output cmd_valid_i, cmd_we_i, cmd_sel_i, cmd_adr_i, cmd_dat_i,
        input  cmd_ready_o,
        input  rsp_valid_o, rsp_dat_o, rsp_err_o,
        output rsp_ready_i,
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        output wbm_dat_i, wbm_ack_i
    );
endinterface

// File: rtl/wb_master_bridge.sv
// Wishbone classic initiator: one valid/ready command becomes one read or write cycle,
// answered on a valid/ready response port with read data or a timeout error.
module wb_master_bridge #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_ni,
    wb_master_bridge_if.master bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_t          state_q, state_d;
    logic [TO_W-1:0] cnt_q, cnt_d;

    // Every output is a flop; the *_d signals are their next values.
    logic            cmd_ready_q, cmd_ready_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]   rsp_dat_q,   rsp_dat_d;
    logic            rsp_err_q,   rsp_err_d;
    logic            cyc_q,       cyc_d;
    logic            we_q,        we_d;
    logic [DW/8-1:0] sel_q,       sel_d;
    logic [AW-1:0]   adr_q,       adr_d;
    logic [DW-1:0]   dat_q,       dat_d;

    always_comb begin
        // NOTE: every signal gets its hold value first so no path through the case leaves it unassigned (no latches).
        state_d     = state_q;
        cnt_d       = cnt_q;
        cmd_ready_d = cmd_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_err_d   = rsp_err_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        sel_d       = sel_q;
        adr_d       = adr_q;
        dat_d       = dat_q;

        unique case (state_q)
            IDLE: begin
                if (bus.cmd_valid_i) begin
                    state_d     = BUS;
                    cnt_d       = '0;
                    cmd_ready_d = 1'b0;
                    cyc_d       = 1'b1;
                    we_d        = bus.cmd_we_i;
                    sel_d       = bus.cmd_sel_i;
                    adr_d       = bus.cmd_adr_i;
                    dat_d       = bus.cmd_dat_i;
                end
            end

            BUS: begin
                // ACK is checked before the timeout so a last-cycle ACK still completes cleanly.
                if (bus.wbm_ack_i) begin
                    state_d     = RESP;
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_dat_d   = we_q ? '0 : bus.wbm_dat_i;
                end else if (cnt_q == TO_LAST) begin
                    state_d     = RESP;
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_dat_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            RESP: begin
                if (bus.rsp_ready_i) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                end
            end

            default: begin
                state_d     = IDLE;
                cyc_d       = 1'b0;
                rsp_valid_d = 1'b0;
                cmd_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        // NOTE: reset is synchronous, so it sits inside the clocked branch and all state uses non-blocking assignments.
        if (!wb_rst_ni) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            adr_q       <= '0;
            dat_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
        end
    end

    // Classic single cycles: STB always tracks CYC.
    assign bus.cmd_ready_o = cmd_ready_q;
    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_dat_o   = rsp_dat_q;
    assign bus.rsp_err_o   = rsp_err_q;
    assign bus.wbm_cyc_o   = cyc_q;
    assign bus.wbm_stb_o   = cyc_q;
    assign bus.wbm_we_o    = we_q;
    assign bus.wbm_sel_o   = sel_q;
    assign bus.wbm_adr_o   = adr_q;
    assign bus.wbm_dat_o   = dat_q;

endmodule
